obi_host_pipelined: RTL and testbench
=====================================

# obi_host_pipelined

Parametrised OBI host-side request driver that supports up to `MAX_OUTSTANDING` in-order transactions in flight. It replaces the single-outstanding driver on the instruction and data memory ports. It presents pipeline memory requests on the bus in the same cycle they are issued. If the bus does not grant a request, the driver captures it and replays it unchanged. It stalls the pipeline when a request is held or when the outstanding limit is reached. Responses are classified as read data or write acknowledgements using an internal tag FIFO.

## Interface
Parameters:
- `ADDR_W`, default 64: address width.
- `DATA_W`, default 64: data width; must be a multiple of 8.
- `MAX_OUTSTANDING`, default 2: maximum number of granted but unanswered transactions; must be ≥1.

Ports:
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: reset, synchronous, active-high.
- `rd_i` in 1: pipeline read request.
- `wr_i` in 1: pipeline write request; `rd_i` and `wr_i` are never both 1.
- `be_i` in DATA_W/8: byte enables.
- `addr_i` in ADDR_W: request address.
- `wdata_i` in DATA_W: write data.
- `gnt_i` in 1: bus grant.
- `rvalid_i` in 1: bus response valid.
- `rdata_i` in DATA_W: bus read data.
- `stall_o` out 1: pipeline must hold its request inputs and not advance.
- `req_o` out 1: bus request.
- `we_o` out 1: bus write enable.
- `be_o` out DATA_W/8: bus byte enables.
- `addr_o` out ADDR_W: bus address.
- `wdata_o` out DATA_W: bus write data.
- `rvalid_o` out 1: read data valid this cycle.
- `rdata_o` out DATA_W: read data; passthrough of `rdata_i`.
- `wack_o` out 1: write acknowledged this cycle.
- `outstanding_o` out $clog2(MAX_OUTSTANDING+1): current in-flight count.

## Operation
State:
- `hold_q` plus saved `we`, `be`, `addr` and `wdata` registers.
- Counter `cnt_q` in 0..MAX_OUTSTANDING.
- Tag FIFO: depth MAX_OUTSTANDING, entry = `we` bit.

Signals:
- `full` = (cnt_q == MAX_OUTSTANDING). A response arriving in the same cycle does not free a slot; issue resumes in the next cycle.
- `live` = rd_i | wr_i.

States:
- IDLE/PASS (hold_q=0):
  - req_o = live & ~full.
  - Bus outputs are driven directly from the `*_i` inputs.
  - If req_o & ~gnt_i: capture the inputs into the saved registers and set hold_q (enter HOLD).
- HOLD (hold_q=1):
  - req_o = 1.
  - Bus outputs are driven from the saved registers; the `*_i` inputs are ignored.
  - On gnt_i: clear hold_q (return to PASS).

Grant and response bookkeeping:
- Grant accepted = req_o & gnt_i. On acceptance, push `we_o` into the tag FIFO and increment cnt_q.
- Response retire = rvalid_i & (cnt_q != 0). On retire, pop the FIFO and decrement cnt_q.
  - rvalid_o = retire & ~head.
  - wack_o = retire & head.
- Simultaneous accept and retire: cnt_q unchanged; FIFO pushes and pops in the same cycle, including when full.
- rvalid_i with cnt_q == 0 is a protocol violation: ignored, no outputs, cnt_q stays 0.
- stall_o = hold_q | (live & full).
- The driver never stalls while waiting for read data. Consumers use rvalid_o.

## Timing
- Reset (rst_i=1 at an edge):
  - hold_q, cnt_q and the FIFO pointers clear; saved registers clear to 0.
  - Outputs after reset: req_o=0, stall_o=0, rvalid_o=0, wack_o=0, outstanding_o=0. The bus outputs equal the `*_i` inputs, since they are combinational in PASS.
- Reset mid-operation: all in-flight tracking is discarded. Responses arriving later are dropped as protocol violations.
- Request path latency is 0 cycles in PASS: inputs appear on the bus in the same cycle.
- Unanswered request: captured at the edge; stall_o=1 from the next cycle. In the grant cycle stall_o is still 1. stall_o drops 1 cycle after the grant.
- Response path latency is 0 cycles: rvalid_o/wack_o and rdata_o are combinational from rvalid_i.
- cnt_q and outstanding_o update 1 cycle after the accept or retire event.

## Configuration
- `OBI_HOST_ERR_EN` defined:
  - Adds ports `err_i` (in 1), `err_o` (out 1) and `err_addr_o` (out ADDR_W).
  - The tag FIFO also stores the address of each accepted request.
  - err_o = retire & err_i; err_addr_o = FIFO head address.
  - rvalid_o/wack_o still assert on an errored response.
- Not defined: these ports and the address FIFO storage are absent. Behaviour is otherwise identical.

## Test plan
- Back-to-back reads, gnt_i=1, rvalid_i 2 cycles later, MAX_OUTSTANDING=2, addrs 0x100/0x108 → req_o on both cycles, outstanding_o reaches 2. A third read stalls (stall_o=1, req_o=0) until the cycle after the first rvalid_i. rvalid_o returns data in order.
- Write 0xDEADBEEF to 0x40, gnt_i low for 3 cycles, inputs changed after cycle 0 → addr_o/wdata_o stay 0x40/0xDEADBEEF while held. stall_o=1 for cycles 1-3 and 0 in cycle 4.
- Interleaved write, read, write with rvalid_i each cycle after grant → wack_o, rvalid_o, wack_o in that order; the write responses never assert rvalid_o.
- Accept and retire in the same cycle at cnt_q=1 → outstanding_o stays 1 and FIFO order is preserved.
- rvalid_i pulse with cnt_q=0, then rst_i asserted with 2 outstanding → no rvalid_o/wack_o; after reset outstanding_o=0 and late responses are ignored.
- With OBI_HOST_ERR_EN: read of 0x2000, response with err_i=1 → err_o=1, err_addr_o=0x2000, rvalid_o=1.

Source files
------------

// File: rtl/obi_host_pipelined.sv
// OBI host request driver with up to MAX_OUTSTANDING in-order transactions in flight.
// Optional error reporting (err_i/err_o/err_addr_o) is enabled by defining OBI_HOST_ERR_EN.
module obi_host_pipelined #(
   parameter int ADDR_W          = 64,
   parameter int DATA_W          = 64,
   parameter int MAX_OUTSTANDING = 2
) (
   input  logic                                   clk_i,
   input  logic                                   rst_i,
   input  logic                                   rd_i,
   input  logic                                   wr_i,
   input  logic [DATA_W/8-1:0]                    be_i,
   input  logic [ADDR_W-1:0]                      addr_i,
   input  logic [DATA_W-1:0]                      wdata_i,
   input  logic                                   gnt_i,
   input  logic                                   rvalid_i,
   input  logic [DATA_W-1:0]                      rdata_i,
   output logic                                   stall_o,
   output logic                                   req_o,
   output logic                                   we_o,
   output logic [DATA_W/8-1:0]                    be_o,
   output logic [ADDR_W-1:0]                      addr_o,
   output logic [DATA_W-1:0]                      wdata_o,
   output logic                                   rvalid_o,
   output logic [DATA_W-1:0]                      rdata_o,
   output logic                                   wack_o,
`ifdef OBI_HOST_ERR_EN
   input  logic                                   err_i,
   output logic                                   err_o,
   output logic [ADDR_W-1:0]                      err_addr_o,
`endif
   output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
   localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
   localparam int BE_W  = DATA_W / 8;

   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

   localparam logic ST_PASS = 1'b0;
   localparam logic ST_HOLD = 1'b1;

   logic                hold_q, hold_d;
   logic                sv_we_q;
   logic [BE_W-1:0]     sv_be_q;
   logic [ADDR_W-1:0]   sv_addr_q;
   logic [DATA_W-1:0]   sv_wdata_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic                tag_q [MAX_OUTSTANDING];

   logic live_s, full_s, accept_s, retire_s, capture_s, head_s;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      if (p == PTR_LAST) begin
         return PTR_ZERO;
      end else begin
         return p + PTR_ONE;
      end
   endfunction

   // Bus request muxing, bookkeeping events and next-state selection
   always_comb begin
      live_s    = rd_i | wr_i;
      full_s    = (cnt_q == CNT_MAX);
      req_o     = 1'b0;
      we_o      = wr_i;
      be_o      = be_i;
      addr_o    = addr_i;
      wdata_o   = wdata_i;
      hold_d    = ST_PASS;
      capture_s = 1'b0;
      case (hold_q)
         ST_PASS: begin
            req_o     = live_s & ~full_s;
            capture_s = req_o & ~gnt_i;
            hold_d    = capture_s ? ST_HOLD : ST_PASS;
         end
         ST_HOLD: begin
            req_o   = 1'b1;
            we_o    = sv_we_q;
            be_o    = sv_be_q;
            addr_o  = sv_addr_q;
            wdata_o = sv_wdata_q;
            hold_d  = gnt_i ? ST_PASS : ST_HOLD;
         end
         default: begin
            req_o  = 1'b0;
            hold_d = ST_PASS;
         end
      endcase

      accept_s = req_o & gnt_i;
      retire_s = rvalid_i & (cnt_q != CNT_ZERO);
      head_s   = tag_q[rd_ptr_q];
      rvalid_o = retire_s & ~head_s;
      wack_o   = retire_s & head_s;
      rdata_o  = rdata_i;
      stall_o  = hold_q | (live_s & full_s);

      case ({accept_s, retire_s})
         2'b10:   cnt_d = cnt_q + CNT_ONE;
         2'b01:   cnt_d = cnt_q - CNT_ONE;
         default: cnt_d = cnt_q;
      endcase
      outstanding_o = cnt_q;
   end

   // Hold/replay registers, in-flight counter and tag FIFO
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hold_q     <= ST_PASS;
         sv_we_q    <= 1'b0;
         sv_be_q    <= {BE_W{1'b0}};
         sv_addr_q  <= {ADDR_W{1'b0}};
         sv_wdata_q <= {DATA_W{1'b0}};
         cnt_q      <= CNT_ZERO;
         wr_ptr_q   <= PTR_ZERO;
         rd_ptr_q   <= PTR_ZERO;
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            tag_q[i] <= 1'b0;
         end
      end else begin
         hold_q <= hold_d;
         cnt_q  <= cnt_d;
         if (capture_s) begin
            sv_we_q    <= wr_i;
            sv_be_q    <= be_i;
            sv_addr_q  <= addr_i;
            sv_wdata_q <= wdata_i;
         end
         if (accept_s) begin
            tag_q[wr_ptr_q] <= we_o;
            wr_ptr_q        <= ptr_next(wr_ptr_q);
         end
         if (retire_s) begin
            rd_ptr_q <= ptr_next(rd_ptr_q);
         end
      end
   end

`ifdef OBI_HOST_ERR_EN
   logic [ADDR_W-1:0] addr_fifo_q [MAX_OUTSTANDING];

   // Address of each accepted request, reported alongside an errored response
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            addr_fifo_q[i] <= {ADDR_W{1'b0}};
         end
      end else if (accept_s) begin
         addr_fifo_q[wr_ptr_q] <= addr_o;
      end
   end

   assign err_o      = retire_s & err_i;
   assign err_addr_o = addr_fifo_q[rd_ptr_q];
`endif

endmodule

// File: tb/tb_obi_host_pipelined.sv
// Directed self-checking bench for obi_host_pipelined (default parameters).
module tb_obi_host_pipelined;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        rd_i, wr_i, gnt_i, rvalid_i;
   logic [7:0]  be_i;
   logic [63:0] addr_i, wdata_i, rdata_i;
   logic        stall_o, req_o, we_o, rvalid_o, wack_o;
   logic [7:0]  be_o;
   logic [63:0] addr_o, wdata_o, rdata_o;
   logic [1:0]  outstanding_o;
`ifdef OBI_HOST_ERR_EN
   logic        err_i, err_o;
   logic [63:0] err_addr_o;
`endif

   int total  = 0;
   int passed = 0;

   always #5 clk_i = ~clk_i;

   obi_host_pipelined dut (
      .clk_i(clk_i), .rst_i(rst_i), .rd_i(rd_i), .wr_i(wr_i), .be_i(be_i),
      .addr_i(addr_i), .wdata_i(wdata_i), .gnt_i(gnt_i), .rvalid_i(rvalid_i),
      .rdata_i(rdata_i), .stall_o(stall_o), .req_o(req_o), .we_o(we_o),
      .be_o(be_o), .addr_o(addr_o), .wdata_o(wdata_o), .rvalid_o(rvalid_o),
      .rdata_o(rdata_o), .wack_o(wack_o),
`ifdef OBI_HOST_ERR_EN
      .err_i(err_i), .err_o(err_o), .err_addr_o(err_addr_o),
`endif
      .outstanding_o(outstanding_o)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // advance past the next rising edge, then let combinational outputs settle
   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle();
      rd_i = 1'b0; wr_i = 1'b0; gnt_i = 1'b0; rvalid_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1; idle();
      be_i = 8'hFF; addr_i = 64'h55; wdata_i = 64'h77; rdata_i = 64'h0;
`ifdef OBI_HOST_ERR_EN
      err_i = 1'b0;
`endif
      tick(); tick();
      rst_i = 1'b0; #1;
      chk("rst_req", req_o, 1'b0);
      chk("rst_stall", stall_o, 1'b0);
      chk("rst_rvalid", rvalid_o, 1'b0);
      chk("rst_wack", wack_o, 1'b0);
      chk("rst_outst", outstanding_o, 2'd0);
      chk("rst_addr_pass", addr_o, 64'h55);

      // back-to-back reads
      rd_i = 1'b1; gnt_i = 1'b1; addr_i = 64'h100; #1;
      chk("rd0_req", req_o, 1'b1);
      chk("rd0_we", we_o, 1'b0);
      chk("rd0_addr", addr_o, 64'h100);
      chk("rd0_stall", stall_o, 1'b0);
      tick();
      addr_i = 64'h108; #1;
      chk("rd1_req", req_o, 1'b1);
      chk("rd1_outst", outstanding_o, 2'd1);
      tick();
      addr_i = 64'h110; rvalid_i = 1'b1; rdata_i = 64'hAAAA; #1;
      chk("rd2_outst", outstanding_o, 2'd2);
      chk("rd2_req_full", req_o, 1'b0);
      chk("rd2_stall_full", stall_o, 1'b1);
      chk("rsp0_rvalid", rvalid_o, 1'b1);
      chk("rsp0_rdata", rdata_o, 64'hAAAA);
      chk("rsp0_wack", wack_o, 1'b0);
      tick();
      rdata_i = 64'hBBBB; #1;
      chk("rd2_req", req_o, 1'b1);
      chk("rd2_stall", stall_o, 1'b0);
      chk("rsp1_rvalid", rvalid_o, 1'b1);
      chk("rsp1_rdata", rdata_o, 64'hBBBB);
      chk("rd2_outst1", outstanding_o, 2'd1);
      tick();
      rd_i = 1'b0; gnt_i = 1'b0; rdata_i = 64'hCCCC; #1;
      chk("rsp2_rvalid", rvalid_o, 1'b1);
      chk("rsp2_outst", outstanding_o, 2'd1);
      tick();
      rvalid_i = 1'b0; #1;
      chk("rd_drain", outstanding_o, 2'd0);

      // held write replays unchanged
      wr_i = 1'b1; addr_i = 64'h40; wdata_i = 64'hDEADBEEF; be_i = 8'h0F; #1;
      chk("wh0_req", req_o, 1'b1);
      chk("wh0_we", we_o, 1'b1);
      chk("wh0_stall", stall_o, 1'b0);
      tick();
      wr_i = 1'b0; rd_i = 1'b1; addr_i = 64'h999; wdata_i = 64'h1234; be_i = 8'hF0; #1;
      chk("wh1_stall", stall_o, 1'b1);
      chk("wh1_req", req_o, 1'b1);
      chk("wh1_we", we_o, 1'b1);
      chk("wh1_addr", addr_o, 64'h40);
      chk("wh1_wdata", wdata_o, 64'hDEADBEEF);
      chk("wh1_be", be_o, 8'h0F);
      tick();
      chk("wh2_stall", stall_o, 1'b1);
      chk("wh2_addr", addr_o, 64'h40);
      tick();
      gnt_i = 1'b1; #1;
      chk("wh3_stall", stall_o, 1'b1);
      chk("wh3_wdata", wdata_o, 64'hDEADBEEF);
      chk("wh3_outst", outstanding_o, 2'd0);
      tick();
      idle(); #1;
      chk("wh4_stall", stall_o, 1'b0);
      chk("wh4_req", req_o, 1'b0);
      chk("wh4_outst", outstanding_o, 2'd1);
      rvalid_i = 1'b1; #1;
      chk("wh_wack", wack_o, 1'b1);
      chk("wh_rvalid", rvalid_o, 1'b0);
      tick();
      idle(); #1;
      chk("wh_drain", outstanding_o, 2'd0);

      // interleaved write, read, write
      wr_i = 1'b1; gnt_i = 1'b1; addr_i = 64'h200; #1;
      chk("iw0_we", we_o, 1'b1);
      tick();
      wr_i = 1'b0; rd_i = 1'b1; addr_i = 64'h208; rvalid_i = 1'b1; #1;
      chk("iw1_wack", wack_o, 1'b1);
      chk("iw1_rvalid", rvalid_o, 1'b0);
      chk("iw1_outst", outstanding_o, 2'd1);
      tick();
      rd_i = 1'b0; wr_i = 1'b1; addr_i = 64'h210; #1;
      chk("iw2_rvalid", rvalid_o, 1'b1);
      chk("iw2_wack", wack_o, 1'b0);
      chk("iw2_outst", outstanding_o, 2'd1);
      tick();
      wr_i = 1'b0; gnt_i = 1'b0; #1;
      chk("iw3_wack", wack_o, 1'b1);
      chk("iw3_rvalid", rvalid_o, 1'b0);
      chk("iw3_outst", outstanding_o, 2'd1);
      tick();
      idle(); #1;
      chk("iw_drain", outstanding_o, 2'd0);

      // stray response and reset with transactions in flight
      rvalid_i = 1'b1; #1;
      chk("stray_rvalid", rvalid_o, 1'b0);
      chk("stray_wack", wack_o, 1'b0);
      tick();
      rvalid_i = 1'b0; #1;
      chk("stray_outst", outstanding_o, 2'd0);
      rd_i = 1'b1; gnt_i = 1'b1; addr_i = 64'h300;
      tick();
      tick();
      idle(); #1;
      chk("pre_rst_outst", outstanding_o, 2'd2);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0; #1;
      chk("post_rst_outst", outstanding_o, 2'd0);
      rvalid_i = 1'b1; #1;
      chk("late_rvalid", rvalid_o, 1'b0);
      chk("late_wack", wack_o, 1'b0);
      tick();
      idle(); #1;
      chk("late_outst", outstanding_o, 2'd0);

`ifdef OBI_HOST_ERR_EN
      rd_i = 1'b1; gnt_i = 1'b1; addr_i = 64'h2000;
      tick();
      idle(); addr_i = 64'h0; rvalid_i = 1'b1; err_i = 1'b1; #1;
      chk("err_o", err_o, 1'b1);
      chk("err_addr", err_addr_o, 64'h2000);
      chk("err_rvalid", rvalid_o, 1'b1);
      tick();
      idle(); err_i = 1'b0;
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
